// File: rtl/fproc_pkg.sv
// Shared types and response codes for the fproc measurement responder.
package fproc_pkg;

  localparam int unsigned FPROC_DATA_W = 32;
  localparam int unsigned FPROC_ID_W   = 8;

  localparam logic [FPROC_DATA_W-1:0] FPROC_BAD_ID  = 32'hFFFF_FFFE;
  localparam logic [FPROC_DATA_W-1:0] FPROC_TIMEOUT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } chan_state_e;

endpackage

// File: rtl/fproc_resp_chan.sv
// One core's request/response FSM: IDLE -> WAIT (for meas_valid[id]) -> RESP -> IDLE.
// Optional WAIT timeout is enabled by defining FPROC_TIMEOUT_EN.
module fproc_resp_chan
  import fproc_pkg::*;
#(
  parameter int unsigned N_MEAS         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic [FPROC_ID_W-1:0]   id,
  input  logic [N_MEAS-1:0]       meas,
  input  logic [N_MEAS-1:0]       meas_valid,
  output logic [FPROC_DATA_W-1:0] data,
  output logic                    ready
);

  chan_state_e             state_q, state_d;
  logic [FPROC_ID_W-1:0]   id_q, id_d;
  logic [FPROC_DATA_W-1:0] data_q, data_d;

  logic [FPROC_ID_W-1:0] sel_id;
  logic                  sel_in_range;
  logic                  sel_valid;
  logic                  sel_meas;

`ifdef FPROC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_done;
  assign cnt_done = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // In IDLE the live request id is decoded so a same-cycle meas_valid is not missed.
  always_comb begin
    sel_id       = (state_q == StIdle) ? id : id_q;
    sel_in_range = 1'b0;
    sel_valid    = 1'b0;
    sel_meas     = 1'b0;
    for (int i = 0; i < int'(N_MEAS); i++) begin
      if (sel_id == FPROC_ID_W'(i)) begin
        sel_in_range = 1'b1;
        sel_valid    = meas_valid[i];
        sel_meas     = meas[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    data_d  = data_q;
`ifdef FPROC_TIMEOUT_EN
    cnt_d   = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          id_d = id;
          if (!sel_in_range) begin
            data_d  = FPROC_BAD_ID;
            state_d = StResp;
          end else if (sel_valid) begin
            data_d  = {{(FPROC_DATA_W-1){1'b0}}, sel_meas};
            state_d = StResp;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (sel_valid) begin
          data_d  = {{(FPROC_DATA_W-1){1'b0}}, sel_meas};
          state_d = StResp;
        end
`ifdef FPROC_TIMEOUT_EN
        else if (cnt_done) begin
          data_d  = FPROC_TIMEOUT;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

`ifdef FPROC_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign ready = (state_q == StResp);
  assign data  = data_q;

endmodule

// File: rtl/fproc_meas_resp.sv
// Per-core measurement responder: slices the core buses onto N_CORES channel FSMs.
// Optional WAIT timeout is enabled by defining FPROC_TIMEOUT_EN.
module fproc_meas_resp
  import fproc_pkg::*;
#(
  parameter int unsigned N_CORES        = 2,
  parameter int unsigned N_MEAS         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_CORES-1:0]              fproc_req,
  input  logic [FPROC_ID_W*N_CORES-1:0]   fproc_id,
  input  logic [N_MEAS-1:0]               meas,
  input  logic [N_MEAS-1:0]               meas_valid,
  output logic [FPROC_DATA_W*N_CORES-1:0] fproc_data,
  output logic [N_CORES-1:0]              fproc_ready
);

  for (genvar c = 0; c < int'(N_CORES); c++) begin : g_chan
    fproc_resp_chan #(
      .N_MEAS        (N_MEAS),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .req       (fproc_req[c]),
      .id        (fproc_id[c*FPROC_ID_W +: FPROC_ID_W]),
      .meas      (meas),
      .meas_valid(meas_valid),
      .data      (fproc_data[c*FPROC_DATA_W +: FPROC_DATA_W]),
      .ready     (fproc_ready[c])
    );
  end

endmodule

// File: tb/tb_fproc_meas_resp.sv
// Self-checking bench for fproc_meas_resp: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_fproc_meas_resp;

  localparam int NC = 2;
  localparam int NM = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   fproc_req;
  logic [8*NC-1:0] fproc_id;
  logic [NM-1:0]   meas;
  logic [NM-1:0]   meas_valid;
  logic [32*NC-1:0] fproc_data;
  logic [NC-1:0]   fproc_ready;

  fproc_meas_resp #(
    .N_CORES       (NC),
    .N_MEAS        (NM),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fproc_req  (fproc_req),
    .fproc_id   (fproc_id),
    .meas       (meas),
    .meas_valid (meas_valid),
    .fproc_data (fproc_data),
    .fproc_ready(fproc_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: each core either is free, has an outstanding request
  // (pending) with a wait age, or is presenting its answer this cycle.
  bit          m_pending [NC];
  bit          m_answer  [NC];
  int          m_ch      [NC];
  int          m_age     [NC];
  logic [31:0] m_data    [NC];

  function automatic void model_edge();
    for (int c = 0; c < NC; c++) begin
      if (reset) begin
        m_pending[c] = 0;
        m_answer[c]  = 0;
        m_data[c]    = 0;
      end else if (m_answer[c]) begin
        m_answer[c] = 0;
      end else if (m_pending[c]) begin
        if (meas_valid[m_ch[c]]) begin
          m_data[c]    = {31'b0, meas[m_ch[c]]};
          m_pending[c] = 0;
          m_answer[c]  = 1;
        end else begin
          m_age[c]++;
`ifdef FPROC_TIMEOUT_EN
          if (m_age[c] == TO) begin
            m_data[c]    = 32'hFFFF_FFFF;
            m_pending[c] = 0;
            m_answer[c]  = 1;
          end
`endif
        end
      end else if (fproc_req[c]) begin
        int rid;
        rid = int'(fproc_id[c*8 +: 8]);
        if (rid >= NM) begin
          m_data[c]   = 32'hFFFF_FFFE;
          m_answer[c] = 1;
        end else if (meas_valid[rid]) begin
          m_data[c]   = {31'b0, meas[rid]};
          m_answer[c] = 1;
        end else begin
          m_ch[c]      = rid;
          m_age[c]     = 0;
          m_pending[c] = 1;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NC; c++) begin
      check($sformatf("model_ready[%0d]", c), 32'(fproc_ready[c]), 32'(m_answer[c]));
      check($sformatf("model_data[%0d]", c), fproc_data[c*32 +: 32], m_data[c]);
    end
  endtask

  task automatic idle_inputs();
    fproc_req  = '0;
    meas_valid = '0;
  endtask

  initial begin
    reset      = 1'b1;
    fproc_req  = '0;
    fproc_id   = '0;
    meas       = '0;
    meas_valid = '0;
    for (int c = 0; c < NC; c++) begin
      m_pending[c] = 0; m_answer[c] = 0; m_ch[c] = 0; m_age[c] = 0; m_data[c] = 0;
    end
    step();
    step();
    check("reset_ready", 32'(fproc_ready), 32'd0);
    check("reset_data", fproc_data[31:0], 32'd0);
    reset = 1'b0;
    step();

    // Core0 waits on channel 3, answered four cycles later.
    fproc_req[0] = 1'b1; fproc_id[7:0] = 8'd3;
    step();
    idle_inputs();
    check("wait_no_ready", 32'(fproc_ready[0]), 32'd0);
    repeat (4) step();
    meas_valid[3] = 1'b1; meas[3] = 1'b1;
    step();
    idle_inputs();
    check("wait_resp_ready", 32'(fproc_ready[0]), 32'd1);
    check("wait_resp_data", fproc_data[31:0], 32'h1);
    step();
    check("wait_back_idle", 32'(fproc_ready[0]), 32'd0);
    check("wait_data_held", fproc_data[31:0], 32'h1);

    // Same-cycle request and result.
    fproc_req[0] = 1'b1; fproc_id[7:0] = 8'd2; meas_valid[2] = 1'b1; meas[2] = 1'b0;
    step();
    idle_inputs();
    check("same_cycle_ready", 32'(fproc_ready[0]), 32'd1);
    check("same_cycle_data", fproc_data[31:0], 32'h0);
    step();

    // Both cores on channel 5, released together.
    fproc_req = 2'b11; fproc_id = {8'd5, 8'd5};
    step();
    idle_inputs();
    step();
    meas_valid[5] = 1'b1; meas[5] = 1'b1;
    step();
    idle_inputs();
    check("shared_ready", 32'(fproc_ready), 32'd3);
    check("shared_data0", fproc_data[31:0], 32'h1);
    check("shared_data1", fproc_data[63:32], 32'h1);
    step();

    // Out-of-range channel id.
    fproc_req[1] = 1'b1; fproc_id[15:8] = 8'd9;
    step();
    idle_inputs();
    check("bad_id_ready", 32'(fproc_ready[1]), 32'd1);
    check("bad_id_data", fproc_data[63:32], 32'hFFFF_FFFE);
    step();

    // Reset aborts a waiting core; a later strobe must not answer it.
    fproc_req[0] = 1'b1; fproc_id[7:0] = 8'd1;
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0; meas_valid[1] = 1'b1; meas[1] = 1'b1;
    step();
    idle_inputs();
    check("abort_ready", 32'(fproc_ready), 32'd0);
    check("abort_data0", fproc_data[31:0], 32'd0);
    step();
    check("abort_ready_late", 32'(fproc_ready), 32'd0);

`ifdef FPROC_TIMEOUT_EN
    // Timeout with an ignored re-request during WAIT.
    fproc_req[0] = 1'b1; fproc_id[7:0] = 8'd4;
    step();
    idle_inputs();
    for (int k = 2; k <= TO; k++) begin
      if (k == 6) begin
        fproc_req[0] = 1'b1; fproc_id[7:0] = 8'd9;
      end
      step();
      fproc_req[0] = 1'b0;
      check("timeout_wait", 32'(fproc_ready[0]), 32'd0);
    end
    step();
    check("timeout_ready", 32'(fproc_ready[0]), 32'd1);
    check("timeout_data", fproc_data[31:0], 32'hFFFF_FFFF);
    step();
    check("timeout_idle", 32'(fproc_ready[0]), 32'd0);
`endif

    // Random traffic, including re-requests while busy and occasional reset.
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < NC; c++) begin
        fproc_req[c]      = ($urandom_range(0, 9) < 3);
        fproc_id[c*8 +: 8] = 8'($urandom_range(0, 11));
      end
      for (int i = 0; i < NM; i++) begin
        meas_valid[i] = ($urandom_range(0, 19) < 2);
        meas[i]       = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
